// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO deserializer: FSM state encoding and the
// default word width.
package sipo_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input / parallel output bundle for the deserializer.
// slave  : the deserializer side (takes serial bits, drives the word buffer).
// master : the surrounding logic (drives serial bits and outReady).
interface sipo_deserializer_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             serialIn;
  logic             serialValid;
  logic             frameStart;
  logic [WIDTH-1:0] parallelOut;
  logic             outValid;
  logic             outReady;
  logic             overrun;
  logic             parityError;

  modport slave (
    input  serialIn, serialValid, frameStart, outReady,
    output parallelOut, outValid, overrun, parityError
  );

  modport master (
    output serialIn, serialValid, frameStart, outReady,
    input  parallelOut, outValid, overrun, parityError
  );

endinterface

// File: rtl/sipo_shift_reg.sv
// Shift/placement register for the deserializer. Each load shifts one bit in
// so that, after WIDTH loads, the first bit sits at [WIDTH-1] (MSB_FIRST=1)
// or at [0] (MSB_FIRST=0). A load together with clear starts a fresh word
// whose only content is the incoming bit. o_next exposes the value the
// register takes on a load so the caller can capture a word on the same edge
// that accepts its final bit.
module sipo_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             _reset,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_next;

  // Compute the post-shift value, starting from zero when a new frame begins.
  always_comb begin
    w_base = i_clear ? '0 : r_q;
    if (MSB_FIRST) begin
      w_next = {w_base[WIDTH-2:0], i_bit};
    end else begin
      w_next = {i_bit, w_base[WIDTH-1:1]};
    end
  end

  // Shift register state; cleared asynchronously by reset.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= w_next;
    end else if (i_clear) begin
      r_q <= '0;
    end
  end

  assign o_q    = r_q;
  assign o_next = w_next;

endmodule

// File: rtl/sipo_deserializer.sv
// Parametrised serial-in/parallel-out deserializer. Frames a gated serial
// stream into WIDTH-bit words (bit order set by MSB_FIRST) and presents each
// word through a one-deep valid/ready buffer. A word completing while the
// buffer is full and not being consumed is dropped and flagged on overrun.
// Optional feature macro: DESER_PARITY_EN adds a trailing even-parity bit per
// frame and reports the check on parityError (tied 0 when undefined).
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                 clock,
  input logic                 _reset,
  sipo_deserializer_if.slave  bus
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] w_bit_cnt_nxt;
  logic             w_load;
  logic             w_clear;
  logic             w_complete;

  logic [WIDTH-1:0] w_shift_q;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] w_word;
  logic             w_word_par;

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_overrun;
  logic             r_par_err;

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clock   (clock),
    ._reset  (_reset),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_bit   (bus.serialIn),
    .o_q     (w_shift_q),
    .o_next  (w_shift_next)
  );

  // FSM state and bit counter registers.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  // Next-state logic: frameStart restarts framing from any state; otherwise
  // bits accumulate in SHIFT until the last data bit (then the parity bit).
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_load        = 1'b0;
    w_clear       = 1'b0;
    w_complete    = 1'b0;
    if (bus.serialValid) begin
      if (bus.frameStart) begin
        w_state_nxt   = SHIFT;
        w_bit_cnt_nxt = CNT_ONE;
        w_load        = 1'b1;
        w_clear       = 1'b1;
      end else begin
        unique case (r_state)
          SHIFT: begin
            w_load = 1'b1;
            if (r_bit_cnt == LAST_BIT) begin
`ifdef DESER_PARITY_EN
              w_state_nxt   = PARITY;
              w_bit_cnt_nxt = r_bit_cnt + CNT_ONE;
`else
              w_state_nxt   = IDLE;
              w_bit_cnt_nxt = '0;
              w_complete    = 1'b1;
`endif
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + CNT_ONE;
            end
          end
          PARITY: begin
            w_state_nxt   = IDLE;
            w_bit_cnt_nxt = '0;
            w_complete    = 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef DESER_PARITY_EN
  logic r_par_acc;

  // Running XOR of the data bits of the current frame.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      r_par_acc <= 1'b0;
    end else if (w_load) begin
      r_par_acc <= (w_clear ? 1'b0 : r_par_acc) ^ bus.serialIn;
    end
  end

  // The word is already complete in the shift register when the parity bit
  // arrives; the parity bit itself folds into the error flag.
  assign w_word     = w_shift_q;
  assign w_word_par = r_par_acc ^ bus.serialIn;
`else
  // Completion happens on the last data bit, so capture the post-shift value.
  assign w_word     = w_shift_next;
  assign w_word_par = 1'b0;
`endif

  // One-deep output buffer with overrun detection on a full, stalled buffer.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_par_err   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_complete) begin
        if (!r_out_valid || bus.outReady) begin
          r_out_data  <= w_word;
          r_out_valid <= 1'b1;
          r_par_err   <= w_word_par;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_out_valid && bus.outReady) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.parallelOut = r_out_data;
  assign bus.outValid    = r_out_valid;
  assign bus.overrun     = r_overrun;
  assign bus.parityError = r_par_err;

endmodule
